// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, writeback FSM states and
// opcode-class helpers used by the execute and writeback stages.
package isa_pkg;

    localparam logic [4:0] OP_MOV   = 5'b00000;
    localparam logic [4:0] OP_MUL   = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b01011;
    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_JMP   = 5'b01101;
    localparam logic [4:0] OP_BZ    = 5'b01110;
    localparam logic [4:0] OP_BC    = 5'b10110;
    localparam logic [4:0] OP_BP    = 5'b10111;
    localparam logic [4:0] OP_BNZ   = 5'b11000;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_HI = 2'd1,
        ST_HALT  = 2'd2
    } wb_state_e;

    // MUL sits inside the first ALU range; callers treat it separately for the high byte
    function automatic logic op_is_alu(input logic [4:0] op);
        return (op >= 5'b00001 && op <= 5'b00011) ||
               (op >= 5'b00101 && op <= 5'b01010) ||
               (op >= 5'b10000 && op <= 5'b10101);
    endfunction

    function automatic logic op_writes_rf(input logic [4:0] op);
        return op_is_alu(op) || op == OP_DIV || op == OP_MOV || op == OP_LOAD;
    endfunction

    function automatic logic op_updates_flags(input logic [4:0] op);
        return op_is_alu(op) || op == OP_DIV || op == OP_CMP;
    endfunction

endpackage

// File: rtl/writeback_stage_branch.sv
// Branch-condition evaluation: decides whether a conditional branch opcode
// is taken given the flag register contents held before the instruction.
module wb_branch_eval
    import isa_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       zero_flag,
    input  logic       carry_flag,
    input  logic       parity_flag,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BZ:   taken = zero_flag;
            OP_BC:   taken = carry_flag;
            OP_BP:   taken = parity_flag;
            OP_BNZ:  taken = !zero_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires executed instructions into the register file,
// data memory, flag register and fetch redirect. Optional WB_RETIRE_CNT_EN adds retire_cnt.
module writeback_stage
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [15:0] result,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        ac_in,
    input  logic        parity_in,
    input  logic [2:0]  rd,
    input  logic [3:0]  mem_addr,
    input  logic [5:0]  instr_mem_addr,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        ac_flag,
    output logic        parity_flag,
    output logic        pc_load,
    output logic [5:0]  pc_target,
`ifdef WB_RETIRE_CNT_EN
    output logic [15:0] retire_cnt,
`endif
    output logic        halted
);

    wb_state_e  r_state;
    logic [2:0] r_hi_rd;
    logic [7:0] r_hi_data;
    logic       w_accept;
    logic       w_taken;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;

    wb_branch_eval u_branch (
        .opcode      (opcode),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .parity_flag (parity_flag),
        .taken       (w_taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hi_rd     <= '0;
            r_hi_data   <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            pc_load     <= 1'b0;
            pc_target   <= '0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
            ac_flag     <= 1'b0;
            parity_flag <= 1'b0;
            halted      <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            mem_we  <= 1'b0;
            pc_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (op_writes_rf(opcode)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= result[7:0];
                        end
                        if (opcode == OP_STORE) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= mem_addr;
                            mem_wdata <= result[7:0];
                        end
                        if (opcode == OP_JMP || w_taken) begin
                            pc_load   <= 1'b1;
                            pc_target <= instr_mem_addr;
                        end
                        if (op_updates_flags(opcode)) begin
                            zero_flag   <= zero_in;
                            carry_flag  <= carry_in;
                            ac_flag     <= ac_in;
                            parity_flag <= parity_in;
                        end
                        // high byte goes to rd+1, wrapping within the 8-entry file
                        if (opcode == OP_MUL || opcode == OP_DIV) begin
                            r_hi_rd   <= rd + 3'd1;
                            r_hi_data <= result[15:8];
                            r_state   <= ST_WR_HI;
                        end
                        if (opcode == OP_HALT) begin
                            halted  <= 1'b1;
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_WR_HI: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= r_hi_rd;
                    rf_wdata <= r_hi_data;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retire_cnt <= '0;
        else if (w_accept)
            retire_cnt <= retire_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed instructions push expected
// writes/redirects; a negedge monitor pops and compares every output pulse.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = '0;
    logic [15:0] result = '0;
    logic        zero_in = 1'b0, carry_in = 1'b0, ac_in = 1'b0, parity_in = 1'b0;
    logic [2:0]  rd = '0;
    logic [3:0]  mem_addr = '0;
    logic [5:0]  instr_mem_addr = '0;
    logic        rf_we, mem_we, pc_load, halted;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata, mem_wdata;
    logic [3:0]  mem_waddr;
    logic [5:0]  pc_target;
    logic        zero_flag, carry_flag, ac_flag, parity_flag;
`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    typedef struct packed {
        logic [1:0] kind;   // 0 = reg write, 1 = mem write, 2 = pc redirect
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  n_issued = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .result(result),
        .zero_in(zero_in), .carry_in(carry_in), .ac_in(ac_in), .parity_in(parity_in),
        .rd(rd), .mem_addr(mem_addr), .instr_mem_addr(instr_mem_addr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .ac_flag(ac_flag), .parity_flag(parity_flag),
        .pc_load(pc_load), .pc_target(pc_target),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .halted(halted)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_rf(input logic [2:0] a, input logic [7:0] d);
        sb.push_back('{kind: 2'd0, addr: {3'b000, a}, data: d});
    endtask
    task automatic exp_mem(input logic [3:0] a, input logic [7:0] d);
        sb.push_back('{kind: 2'd1, addr: {2'b00, a}, data: d});
    endtask
    task automatic exp_pc(input logic [5:0] a);
        sb.push_back('{kind: 2'd2, addr: a, data: 8'h00});
    endtask

    // fl = {zero, carry, ac, parity}; returns just after the accepting edge
    task automatic issue(input logic [4:0] op, input logic [2:0] r, input logic [15:0] res,
                         input logic [3:0] fl, input logic [3:0] ma, input logic [5:0] ia);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for op %b, required 1", op);
        end else begin
            opcode = op; rd = r; result = res;
            {zero_in, carry_in, ac_in, parity_in} = fl;
            mem_addr = ma; instr_mem_addr = ia;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_issued++;
        end
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk(name, int'({zero_flag, carry_flag, ac_flag, parity_flag}), int'(exp));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outs"}, int'({rf_we, rf_waddr, rf_wdata, mem_we, mem_waddr, mem_wdata,
                                  pc_load, pc_target, halted}), 0);
        chk_flags({tag, "_flags"}, 4'b0000);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
`ifdef WB_RETIRE_CNT_EN
        chk({tag, "_retire_cnt"}, int'(retire_cnt), 0);
`endif
    endtask

    // Monitor: every write/redirect pulse must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t act, e;
        if (rst_n && (rf_we || mem_we || pc_load)) begin
            checks++;
            if (int'(rf_we) + int'(mem_we) + int'(pc_load) > 1) begin
                errors++;
                $display("FAIL onehot: rf_we=%b mem_we=%b pc_load=%b, required at most one", rf_we, mem_we, pc_load);
            end else begin
                if (rf_we)       act = '{kind: 2'd0, addr: {3'b000, rf_waddr}, data: rf_wdata};
                else if (mem_we) act = '{kind: 2'd1, addr: {2'b00, mem_waddr}, data: mem_wdata};
                else             act = '{kind: 2'd2, addr: pc_target, data: 8'h00};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: kind=%0d addr=0x%0h data=0x%0h, required none",
                             act.kind, act.addr, act.data);
                end else begin
                    e = sb.pop_front();
                    if (act != e) begin
                        errors++;
                        $display("FAIL write_match: kind=%0d addr=0x%0h data=0x%0h, required kind=%0d addr=0x%0h data=0x%0h",
                                 act.kind, act.addr, act.data, e.kind, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset0");
        @(negedge clk);
        rst_n = 1'b1;
        n_issued = 0;

        // ADD rd=3
        exp_rf(3'd3, 8'h42);
        issue(5'b00001, 3'd3, 16'h0042, 4'b0101, 4'h0, 6'h00);
        chk_flags("add_flags", 4'b0101);

        // MUL rd=7 wraps high byte to reg0
        exp_rf(3'd7, 8'hEF);
        exp_rf(3'd0, 8'hBE);
        issue(5'b00011, 3'd7, 16'hBEEF, 4'b1010, 4'h0, 6'h00);
        chk("mul_in_ready_hi", int'(in_ready), 0);
        chk_flags("mul_flags", 4'b1010);

        // Store leaves flags alone
        exp_mem(4'hA, 8'h55);
        issue(5'b01100, 3'd0, 16'h0055, 4'b0101, 4'hA, 6'h00);
        chk_flags("store_flags", 4'b1010);

        // Compare then branches on pre-instruction flags
        issue(5'b11001, 3'd0, 16'h0000, 4'b1000, 4'h0, 6'h00);
        chk_flags("cmp_flags", 4'b1000);
        exp_pc(6'h2C);
        issue(5'b01110, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h2C);
        issue(5'b11000, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h11);
        issue(5'b10110, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h12);
        issue(5'b10111, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h13);
        issue(5'b11001, 3'd0, 16'h0000, 4'b0101, 4'h0, 6'h00);
        exp_pc(6'h05);
        issue(5'b10110, 3'd0, 16'h0000, 4'b1111, 4'h0, 6'h05);
        exp_pc(6'h06);
        issue(5'b10111, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h06);
        exp_pc(6'h3F);
        issue(5'b11000, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h3F);
        issue(5'b01110, 3'd0, 16'h0000, 4'b0000, 4'h0, 6'h07);
        chk_flags("branch_flags", 4'b0101);

        // Jump, move, load, ALU
        exp_pc(6'h3A);
        issue(5'b01101, 3'd0, 16'h0000, 4'b1111, 4'h0, 6'h3A);
        exp_rf(3'd5, 8'h34);
        issue(5'b00000, 3'd5, 16'h1234, 4'b1111, 4'h0, 6'h00);
        exp_rf(3'd2, 8'hA7);
        issue(5'b01011, 3'd2, 16'h00A7, 4'b1111, 4'h0, 6'h00);
        chk_flags("mov_load_flags", 4'b0101);
        exp_rf(3'd1, 8'h01);
        issue(5'b10101, 3'd1, 16'hFF01, 4'b0010, 4'h0, 6'h00);
        chk_flags("alu21_flags", 4'b0010);
        exp_rf(3'd6, 8'hC3);
        issue(5'b01010, 3'd6, 16'h00C3, 4'b1000, 4'h0, 6'h00);

        // Undefined opcodes retire silently
        issue(5'b01111, 3'd4, 16'hFFFF, 4'b1111, 4'h3, 6'h3F);
        issue(5'b11010, 3'd4, 16'hFFFF, 4'b1111, 4'h3, 6'h3F);
        chk_flags("undef_flags", 4'b1000);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", int'(retire_cnt), n_issued);
`endif

        // DIV interrupted by reset during WR_HI: only the low byte appears
        exp_rf(3'd4, 8'h22);
        issue(5'b00100, 3'd4, 16'h1122, 4'b0001, 4'h0, 6'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("div_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_issued = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("div_no_hi_write", int'(rf_we), 0);

        // Halt blocks further input until reset
        issue(5'b11111, 3'd0, 16'h0000, 4'b1111, 4'h0, 6'h00);
        chk("halt_halted", int'(halted), 1);
        chk("halt_in_ready", int'(in_ready), 0);
        chk_flags("halt_flags", 4'b0000);
        @(negedge clk);
        opcode = 5'b00001; rd = 3'd1; result = 16'h0099; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("halt_still", int'({halted, in_ready}), 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("halt_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_ready", int'(in_ready), 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 in_valid  input  1  execute stage presents a valid instruction.
REQ-004 in_ready  output  1  block accepts an instruction this cycle.
REQ-005 opcode  input  5  executed opcode, using the ISA encoding.
REQ-006 result  input  16  execute result; [15:8] used only by MUL/DIV.
REQ-007 zero_in, carry_in, ac_in, parity_in  input  1 each  flags from execute.
REQ-008 rd  input  3  destination register; mem_addr  input  4  data-memory address; instr_mem_addr  input  6  jump/branch target.
REQ-009 rf_we  output  1, rf_waddr  output  3, rf_wdata  output  8  register-file write port.
REQ-010 mem_we  output  1, mem_waddr  output  4, mem_wdata  output  8  data-memory write port.
REQ-011 zero_flag, carry_flag, ac_flag, parity_flag  output  1 each  architectural flag register.
REQ-012 pc_load  output  1, pc_target  output  6  redirect to fetch; halted  output  1  CPU halted.

Function
REQ-013 Accept is in_valid && in_ready at a rising edge; all write/redirect outputs are registered and appear the cycle after acceptance as one-cycle pulses.
REQ-014 FSM states: IDLE, WR_HI, HALT; in_ready=1 only in IDLE.
REQ-015 ALU ops 00001-00011, 00101-01010, 10000-10101 and move 00000, load 01011: rf_we=1, rf_waddr=rd, rf_wdata=result[7:0].
REQ-016 MUL 00011 / DIV 00100: cycle 1 writes result[7:0] to rd; FSM enters WR_HI; cycle 2 writes result[15:8] to rd+1 (modulo 8, rd=7 wraps to 0); returns to IDLE.
REQ-017 Store 01100: mem_we=1, mem_waddr=mem_addr, mem_wdata=result[7:0]; no register write.
REQ-018 Jump 01101: pc_load=1, pc_target=instr_mem_addr.
REQ-019 Branches use flag-register values held before this instruction: 01110 if zero_flag, 10110 if carry_flag, 10111 if parity_flag, 11000 if !zero_flag; taken -> pc_load=1, pc_target=instr_mem_addr; not taken -> no output.
REQ-020 Compare 11001: no register/memory write; flags updated.
REQ-021 Flag register loads the four *_in inputs on acceptance of ALU, MUL, DIV and compare ops; move, load, store, jump, branch and halt leave flags unchanged.
REQ-022 Halt 11111: FSM enters HALT; halted=1; in_ready=0 until reset. Undefined opcodes retire with no effect.
REQ-023 At most one of rf_we, mem_we and pc_load is asserted per cycle.

Reset
REQ-024 Reset clears the FSM to IDLE.
REQ-025 Reset clears every output to 0; in_ready is 1 after reset.
REQ-026 Reset mid-WR_HI discards the pending high-byte write.

Configuration
REQ-027 With WB_RETIRE_CNT_EN defined, output retire_cnt (16 bits) is added; it counts accepted instructions, wraps at 0xFFFF->0, and resets to 0. Without the macro, the port and counter are absent.

Structure
REQ-028 Opcode constants and FSM state encodings live in the shared package isa_pkg, which the execute stage also uses.
REQ-029 Branch-condition evaluation is one combinational sub-module, wb_branch_eval (opcode, flags -> taken).

Verification
REQ-030 ADD with rd=3, result=0x0042, zero_in=0 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x42; zero_flag=0.
REQ-031 MUL with rd=7, result=0xBEEF -> cycle 1 writes reg7=0xEF; cycle 2 writes reg0=0xBE; in_ready=0 during cycle 2.
REQ-032 Store with mem_addr=0xA, result=0x0055 -> mem_we=1, mem_waddr=0xA, mem_wdata=0x55; rf_we=0.
REQ-033 Compare with zero_in=1, then branch 01110 with target 0x2C -> pc_load=1, pc_target=0x2C; a following 11000 branch is not taken.
REQ-034 Halt accepted -> halted=1, in_ready=0, further in_valid ignored; reset=0 -> all outputs 0, IDLE.
REQ-035 Reset asserted during WR_HI of a DIV -> no high-byte write occurs; with WB_RETIRE_CNT_EN defined, retire_cnt=0.
